// File: rtl/multdiv_stall_ctrl.sv
// rtl/multdiv_stall_ctrl.sv - mul/div launch, freeze and writeback sequencing plus load-use stall.
// Define MULTDIV_TIMEOUT_EN to compile in the MD_TIMEOUT abort counter.
module multdiv_stall_ctrl #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        md_start_mult,
  output logic        md_start_div,
  output logic        stall,
  output logic        nop_xm,
  output logic        nop_dx,
  output logic        md_wb_valid,
  output logic [4:0]  md_wb_rd,
  output logic [31:0] md_wb_data,
  output logic        md_wb_exc
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, stateNext;
  logic [4:0]  dxOp, dxRd, dxAluop;
  logic [4:0]  fdOp, fdRd, fdRs, fdRt;
  logic        isMd, timeout;
  logic        mdStall, luStall, startMult, startDiv;
  logic        opDiv;
  logic [4:0]  launchRd;
  logic        unusedBits;

  assign dxOp    = dx_ir[31:27];
  assign dxRd    = dx_ir[26:22];
  assign dxAluop = dx_ir[6:2];
  assign fdOp    = fd_ir[31:27];
  assign fdRd    = fd_ir[26:22];
  assign fdRs    = fd_ir[21:17];
  assign fdRt    = fd_ir[16:12];

  assign isMd = (dxOp == 5'd0) && ((dxAluop == 5'b00110) || (dxAluop == 5'b00111));

`ifdef MULTDIV_TIMEOUT_EN
  logic [5:0] cnt;

  assign timeout = (cnt == 6'(MD_TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= 6'd0;
    end else if (state == IDLE && isMd) begin
      cnt <= 6'd0;
    end else if (state == BUSY) begin
      cnt <= cnt + 6'd1;
    end
  end

  assign unusedBits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};
`else
  assign timeout    = 1'b0;
  assign unusedBits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0], 6'(MD_TIMEOUT)};
`endif

  always_comb begin
    stateNext = state;
    mdStall   = 1'b0;
    startMult = 1'b0;
    startDiv  = 1'b0;
    case (state)
      IDLE: begin
        if (isMd) begin
          mdStall   = 1'b1;
          startMult = ~dxAluop[0];
          startDiv  = dxAluop[0];
          stateNext = BUSY;
        end
      end
      BUSY: begin
        mdStall = 1'b1;
        if (md_ready || timeout) begin
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Load-use: only a lw with a real destination that FD actually reads.
  always_comb begin
    luStall = 1'b0;
    if (dxOp == 5'd8 && dxRd != 5'd0) begin
      if ((fdOp == 5'd0 || fdOp == 5'd5 || fdOp == 5'd7 || fdOp == 5'd8) && fdRs == dxRd) luStall = 1'b1;
      if (fdOp == 5'd0 && fdRt == dxRd) luStall = 1'b1;
      if ((fdOp == 5'd7 || fdOp == 5'd2 || fdOp == 5'd6 || fdOp == 5'd4) && fdRd == dxRd) luStall = 1'b1;
    end
  end

  // Reset forces every output low even while DX still holds a mul/div or lw.
  assign md_start_mult = startMult & ~reset;
  assign md_start_div  = startDiv & ~reset;
  assign stall         = (mdStall | luStall) & ~reset;
  assign nop_xm        = mdStall & ~reset;
  assign nop_dx        = luStall & ~mdStall & ~reset;
  assign md_wb_valid   = (state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      opDiv      <= 1'b0;
      launchRd   <= 5'd0;
      md_wb_rd   <= 5'd0;
      md_wb_data <= 32'd0;
      md_wb_exc  <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == IDLE && isMd) begin
        opDiv    <= dxAluop[0];
        launchRd <= dxRd;
      end
      if (state == BUSY) begin
        if (md_ready && !md_exception) begin
          md_wb_rd   <= launchRd;
          md_wb_data <= md_result;
          md_wb_exc  <= 1'b0;
        end else if (md_ready || timeout) begin
          md_wb_rd   <= 5'd30;
          md_wb_data <= opDiv ? 32'd5 : 32'd4;
          md_wb_exc  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// tb/tb_multdiv_stall_ctrl.sv - scoreboard bench for multdiv_stall_ctrl.
module tb_multdiv_stall_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fd_ir = '0, dx_ir = '0, md_result = '0;
  logic        md_ready = 1'b0, md_exception = 1'b0;
  logic        md_start_mult, md_start_div, stall, nop_xm, nop_dx, md_wb_valid, md_wb_exc;
  logic [4:0]  md_wb_rd;
  logic [31:0] md_wb_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { int cycle; logic isDiv; } startExp_t;
  typedef struct { int cycle; logic [4:0] rd; logic [31:0] data; logic exc; } wbExp_t;
  startExp_t startQ[$];
  wbExp_t    wbQ[$];

  multdiv_stall_ctrl #(.MD_TIMEOUT(40)) dut (
    .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir),
    .md_ready(md_ready), .md_exception(md_exception), .md_result(md_result),
    .md_start_mult(md_start_mult), .md_start_div(md_start_div),
    .stall(stall), .nop_xm(nop_xm), .nop_dx(nop_dx),
    .md_wb_valid(md_wb_valid), .md_wb_rd(md_wb_rd), .md_wb_data(md_wb_data), .md_wb_exc(md_wb_exc)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt, input int alu);
    logic [31:0] ir;
    ir = {op[4:0], rd[4:0], rs[4:0], rt[4:0], 5'd0, alu[4:0], 2'b00};
    return ir;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every launch pulse and writeback strobe must match the head of its queue.
  always @(negedge clock) begin
    startExp_t s;
    wbExp_t    w;
    if (md_start_mult || md_start_div) begin
      checks++;
      if (startQ.size() == 0) begin
        failures++;
        $display("FAIL start_unexpected actual=cycle %0d required=none", cyc);
      end else begin
        s = startQ.pop_front();
        if (s.cycle != cyc || md_start_div !== s.isDiv || md_start_mult !== !s.isDiv) begin
          failures++;
          $display("FAIL start actual=cycle %0d mult=%b div=%b required=cycle %0d div=%b",
                   cyc, md_start_mult, md_start_div, s.cycle, s.isDiv);
        end
      end
    end
    if (md_wb_valid) begin
      checks++;
      if (wbQ.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected actual=cycle %0d required=none", cyc);
      end else begin
        w = wbQ.pop_front();
        if (w.cycle != cyc || md_wb_rd !== w.rd || md_wb_data !== w.data || md_wb_exc !== w.exc) begin
          failures++;
          $display("FAIL wb actual=cycle %0d rd=%0d data=%0h exc=%b required=cycle %0d rd=%0d data=%0h exc=%b",
                   cyc, md_wb_rd, md_wb_data, md_wb_exc, w.cycle, w.rd, w.data, w.exc);
        end
      end
    end
  end

  // Called at a drive point (#1 after posedge); returns at the drive point after DONE.
  task automatic runOp(input logic [31:0] ir, input logic isDiv, input int readyAt, input logic rdy,
                       input logic exc, input logic [31:0] res, input logic [4:0] expRd,
                       input logic [31:0] expData, input logic expExc, input string tag);
    startExp_t s;
    wbExp_t    w;
    int        stallCnt, nopCnt;
    dx_ir = ir;
    s.cycle = cyc; s.isDiv = isDiv;
    startQ.push_back(s);
    w.cycle = cyc + readyAt + 1; w.rd = expRd; w.data = expData; w.exc = expExc;
    wbQ.push_back(w);
    stallCnt = 0;
    nopCnt = 0;
    for (int k = 0; k <= readyAt + 1; k++) begin
      if (rdy && k == readyAt) begin
        md_ready = 1'b1; md_exception = exc; md_result = res;
      end
      @(negedge clock);
      if (stall) stallCnt++;
      if (nop_xm) nopCnt++;
      @(posedge clock); #1;
      md_ready = 1'b0; md_exception = 1'b0;
    end
    chk({tag, "_stall_cycles"}, stallCnt, readyAt + 1);
    chk({tag, "_nop_xm_cycles"}, nopCnt, readyAt + 1);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_stall", stall, 0);
    chk("reset_wb_valid", md_wb_valid, 0);
    chk("reset_wb_regs", {md_wb_rd, md_wb_exc}, 0);
    chk("reset_wb_data", md_wb_data, 0);
    @(posedge clock); #1;

    runOp(mk(0, 3, 1, 2, 6), 1'b0, 16, 1'b1, 1'b0, 32'd6, 5'd3, 32'd6, 1'b0, "mul");
    dx_ir = '0;
    repeat (2) @(posedge clock); #1;

    runOp(mk(0, 4, 1, 2, 7), 1'b1, 32, 1'b1, 1'b1, 32'h1234, 5'd30, 32'd5, 1'b1, "divexc");
    dx_ir = '0;
    repeat (2) @(posedge clock); #1;

    runOp(mk(0, 3, 1, 2, 6), 1'b0, 4, 1'b1, 1'b0, 32'd12, 5'd3, 32'd12, 1'b0, "b2b_mul");
    runOp(mk(0, 4, 1, 2, 7), 1'b1, 3, 1'b1, 1'b0, 32'd7, 5'd4, 32'd7, 1'b0, "b2b_div");
    dx_ir = '0;
    repeat (2) @(posedge clock); #1;

`ifdef MULTDIV_TIMEOUT_EN
    runOp(mk(0, 7, 1, 2, 6), 1'b0, 40, 1'b0, 1'b0, 32'd0, 5'd30, 32'd4, 1'b1, "timeout");
    dx_ir = '0;
    repeat (2) @(posedge clock); #1;
`else
    begin
      startExp_t s;
      dx_ir = mk(0, 7, 1, 2, 6);
      s.cycle = cyc; s.isDiv = 1'b0;
      startQ.push_back(s);
      for (int k = 0; k < 200; k++) begin
        @(posedge clock); #1;
      end
      @(negedge clock);
      chk("no_timeout_stall_200", stall, 1);
      reset = 1'b1;
      dx_ir = '0;
      @(posedge clock); #1 reset = 1'b0;
      @(posedge clock); #1;
    end
`endif

    // Load-use cases
    dx_ir = mk(8, 5, 1, 0, 0); fd_ir = mk(0, 6, 5, 1, 0);
    @(negedge clock);
    chk("lu_rs_stall", stall, 1);
    chk("lu_rs_nop_dx", nop_dx, 1);
    chk("lu_rs_nop_xm", nop_xm, 0);
    @(posedge clock); #1 dx_ir = '0;
    @(negedge clock);
    chk("lu_after_bubble_stall", {stall, nop_dx}, 0);
    @(posedge clock); #1 dx_ir = mk(8, 0, 1, 0, 0); fd_ir = mk(0, 6, 0, 1, 0);
    @(negedge clock);
    chk("lu_r0_no_stall", stall, 0);
    @(posedge clock); #1 dx_ir = mk(8, 5, 1, 0, 0); fd_ir = mk(7, 5, 2, 0, 0);
    @(negedge clock);
    chk("lu_sw_rd_stall", stall, 1);
    @(posedge clock); #1 fd_ir = mk(0, 6, 1, 5, 0);
    @(negedge clock);
    chk("lu_rt_stall", stall, 1);
    @(posedge clock); #1 fd_ir = mk(5, 6, 1, 5, 0);
    @(negedge clock);
    chk("lu_addi_rt_ignored", stall, 0);
    @(posedge clock); #1 fd_ir = mk(0, 6, 1, 2, 0);
    @(negedge clock);
    chk("lu_no_match", stall, 0);
    @(posedge clock); #1 dx_ir = '0; fd_ir = '0;
    @(posedge clock); #1;

    // Reset during BUSY cycle 5 abandons the operation
    begin
      startExp_t s;
      dx_ir = mk(0, 9, 1, 2, 6);
      s.cycle = cyc; s.isDiv = 1'b0;
      startQ.push_back(s);
      repeat (5) begin
        @(posedge clock); #1;
      end
      reset = 1'b1;
      #1;
      chk("rst_busy_stall", {stall, nop_xm, nop_dx}, 0);
      chk("rst_busy_start", {md_start_mult, md_start_div}, 0);
      chk("rst_busy_wb", {md_wb_valid, md_wb_rd, md_wb_exc}, 0);
      chk("rst_busy_wb_data", md_wb_data, 0);
      dx_ir = '0;
      @(posedge clock); #1 reset = 1'b0;
      md_ready = 1'b1; md_result = 32'd99;
      @(posedge clock); #1 md_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clock);
        chk("rst_late_ready_no_wb", md_wb_valid, 0);
      end
    end

    repeat (3) @(posedge clock);
    chk("start_queue_drained", startQ.size(), 0);
    chk("wb_queue_drained", wbQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
